mbist_march_ctrl: RTL
=====================

Name: mbist_march_ctrl

Overview:
- Memory-side initiator for the MBIST flow.
- Drives the fault_mem-style single-port interface (write_read/address/wdata) through a March C- sequence and reads back rdata.
- Compares rdata against expected data and reports pass/fail, with first-failure diagnostics.
- Sits between the BIST top-level sequencer (start/done) and the memory under test.

Parameters:
- DATA_WIDTH, 8: memory word width (must be ≥ 1).
- ADDR_WIDTH, 4: address width.
- CAPACITY, 15: highest valid address. Addresses 0..CAPACITY are tested, so N = CAPACITY+1.

Ports:
- clk  input  1  rising-edge clock, shared with the memory.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to run the test. Ignored while busy.
- write_read  output  1  1 = write, 0 = read, sampled by the memory.
- address  output  ADDR_WIDTH  memory address.
- wdata  output  DATA_WIDTH  write data. Must be valid one cycle before the write cycle, because the memory registers wdata.
- rdata  input  DATA_WIDTH  memory read data, two cycles after the read address.
- busy  output  1  test in progress.
- done  output  1  test complete. Level signal, held until the next start or rst.
- fail  output  1  sticky; set on the first miscompare.
- fail_addr  output  ADDR_WIDTH  address of the first miscompare.
- fail_element  output  3  March element index (0..5) of the first miscompare.
- fail_data  output  DATA_WIDTH  rdata value captured at the first miscompare.

Behaviour:
- Reset (sync, active-high): every output is 0, FSM goes to IDLE, compare pipeline is cleared.
  - Reset mid-test aborts immediately. No further writes are issued; write_read is 0 on the next cycle.
- March C- elements (bg0 = all zeros, bg1 = all ones):
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
  - ⇑ runs address 0→CAPACITY; ⇓ runs CAPACITY→0.
- FSM states: IDLE, SETUP, RUN, DRAIN, DONE.
  - IDLE: on start, go to SETUP with element=0; busy=1, done=0, fail and diagnostics cleared.
  - SETUP (1 cycle per element):
    - address = first address of the element, write_read=0, no compare.
    - wdata loaded with the element's write background (E5: bg0) and held constant for the whole element.
    - This satisfies the memory's one-cycle wdata setup.
  - RUN: one operation per cycle, in the element's op order per address.
    - After the last op at the last address: go to SETUP of the next element, or to DRAIN after E5.
  - DRAIN (2 cycles): retire outstanding compares.
  - DONE: busy=0, done=1. Stays until start (→SETUP, a new run) or rst.
- Read/compare timing:
  - A read issued in cycle t (write_read=0) pushes {expected, address, element} into a 2-stage valid pipeline.
  - rdata is compared in cycle t+2.
  - Reads in SETUP cycles are never pushed.
- Write after read at the same address is the next cycle. The memory needs no extra gap.
- Miscompare:
  - If fail=0: set fail and capture fail_addr, fail_element and fail_data, registered one cycle after the compare.
  - Later miscompares change nothing.
  - The test always runs to completion.
- Cycle budget:
  - RUN = 10N cycles; busy is high for 10N+8 cycles.
  - N=16 gives 168 cycles; done rises 169 cycles after start is sampled.
- Address counter has no wrap-around in either direction. The element transition happens exactly at the end address.
- start asserted in the same cycle as rst: rst wins.

Test Plan:
- Fault-free memory, N=16: pulse start → busy high 168 cycles, done=1, fail=0. The bench checks exactly 80 writes and 80 reads, with the correct address order per element.
- Transition fault, rising edge of bit4 blocked at address 5, DATA_WIDTH=8 → fail=1, fail_element=2, fail_addr=5, fail_data=0xEF. done is still asserted after 168 cycles.
- Stuck-at-1 bit0 at address 15 → first fail at E1 (read 0x01 where 0x00 is expected), fail_addr=15, fail_data=0x01. A later E3 miscompare does not overwrite it.
- Assert rst at cycle 50 of a run → next cycle: write_read=0, busy=0, all outputs 0. A fresh start then completes normally with fail=0.
- start pulsed while busy at cycle 20 → ignored; done still at 169. start while in DONE → done drops, a new 168-cycle run begins, and diagnostics are cleared.
- Check wdata timing: wdata equals the write value in the cycle before every write_read=1 cycle. Applies to all elements, including the ⇓ elements' first address (CAPACITY).

Source files
------------

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- initiator for a single-port memory.
// Runs E0 up(w0), E1 up(r0,w1), E2 up(r1,w0), E3 down(r0,w1), E4 down(r1,w0),
// E5 up(r0) over addresses 0..CAPACITY. rdata is checked two cycles after each
// read, and the first miscompare is captured.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            one-cycle run request, ignored while busy
//   write_read       1 = write, 0 = read
//   address, wdata   memory address / write data (wdata set up a cycle early)
//   rdata            memory read data, two cycles after the read address
//   busy, done       test in progress / test complete (level)
//   fail             sticky first-miscompare flag
//   fail_addr, fail_element, fail_data  first-miscompare diagnostics
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [DATA_WIDTH-1:0] fail_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [2:0]            LAST_ELEM = 3'd5;

  state_t                state;
  logic [2:0]            elem;
  logic                  op_idx;
  logic                  drain_cnt;

  // Two-stage read-compare pipeline
  logic                  s1_v, s2_v;
  logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [2:0]            s1_elem, s2_elem;

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] e);
    return (e != 3'd0) && (e != 3'd5);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_bg(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? '1 : '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wr_bg(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? '1 : '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
    return elem_down(e) ? LAST_ADDR : '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] end_addr(input logic [2:0] e);
    return elem_down(e) ? '0 : LAST_ADDR;
  endfunction

  logic last_op;
  logic last_addr;

  always_comb begin
    last_op   = !elem_two_ops(elem) || op_idx;
    last_addr = (address == end_addr(elem));
  end

  // Outputs describe the operation currently presented to the memory; each
  // edge computes the next one. A RUN cycle with write_read=0 is a real read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      elem         <= '0;
      op_idx       <= 1'b0;
      drain_cnt    <= 1'b0;
      write_read   <= 1'b0;
      address      <= '0;
      wdata        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      fail_addr    <= '0;
      fail_element <= '0;
      fail_data    <= '0;
      s1_v         <= 1'b0;
      s1_exp       <= '0;
      s1_addr      <= '0;
      s1_elem      <= '0;
      s2_v         <= 1'b0;
      s2_exp       <= '0;
      s2_addr      <= '0;
      s2_elem      <= '0;
    end else begin
      s1_v    <= (state == S_RUN) && !write_read;
      s1_exp  <= rd_bg(elem);
      s1_addr <= address;
      s1_elem <= elem;
      s2_v    <= s1_v;
      s2_exp  <= s1_exp;
      s2_addr <= s1_addr;
      s2_elem <= s1_elem;

      if (s2_v && (rdata != s2_exp) && !fail) begin
        fail         <= 1'b1;
        fail_addr    <= s2_addr;
        fail_element <= s2_elem;
        fail_data    <= rdata;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_SETUP;
            elem         <= '0;
            op_idx       <= 1'b0;
            write_read   <= 1'b0;
            address      <= first_addr(3'd0);
            wdata        <= wr_bg(3'd0);
            busy         <= 1'b1;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_element <= '0;
            fail_data    <= '0;
          end
        end
        S_SETUP: begin
          state      <= S_RUN;
          op_idx     <= 1'b0;
          write_read <= (elem == 3'd0);
        end
        S_RUN: begin
          if (!last_op) begin
            op_idx     <= 1'b1;
            write_read <= 1'b1;
          end else if (!last_addr) begin
            address    <= elem_down(elem) ? (address - ADDR_ONE) : (address + ADDR_ONE);
            op_idx     <= 1'b0;
            write_read <= (elem == 3'd0);
          end else if (elem == LAST_ELEM) begin
            state      <= S_DRAIN;
            drain_cnt  <= 1'b0;
            write_read <= 1'b0;
          end else begin
            state      <= S_SETUP;
            elem       <= elem + 3'd1;
            address    <= first_addr(elem + 3'd1);
            wdata      <= wr_bg(elem + 3'd1);
            write_read <= 1'b0;
          end
        end
        S_DRAIN: begin
          write_read <= 1'b0;
          if (drain_cnt) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
